// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: round-robin arbitration between two
// write-back requesters plus a sequencer that zeroes x1..x(2**ADDR-1).
module regfile_wb_arbiter #(
    parameter int unsigned DATA = 32,
    parameter int unsigned ADDR = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v0,
    input  logic [ADDR-1:0] a0,
    input  logic [DATA-1:0] d0,
    output logic            r0,
    input  logic            v1,
    input  logic [ADDR-1:0] a1,
    input  logic [DATA-1:0] d1,
    output logic            r1,
    input  logic            clr,
    output logic            busy,
    output logic            clr_done,
    output logic            WE,
    output logic [ADDR-1:0] WA,
    output logic [DATA-1:0] WD
);

    localparam logic [0:0]      ST_ARB   = 1'b0;
    localparam logic [0:0]      ST_CLEAR = 1'b1;
    localparam logic [ADDR-1:0] CNT_LAST = {ADDR{1'b1}};

    logic [0:0]      state;
    logic [0:0]      state_next;
    logic            ptr;      // last granted requester
    logic [ADDR-1:0] cnt;      // next register to clear
    logic            grant0;
    logic            grant1;

    // Next-state and grant decode; ready never depends on the write outputs
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            ST_ARB: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                end else begin
                    grant0 = v0 && (!v1 || ptr);
                    grant1 = v1 && (!v0 || !ptr);
                end
            end
            ST_CLEAR: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_ARB;
                end
            end
            default: state_next = ST_ARB;
        endcase
    end

    assign r0   = grant0;
    assign r1   = grant1;
    assign busy = (state == ST_CLEAR);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ARB;
        end else begin
            state <= state_next;
        end
    end

    // Write-port registers, clear counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            WE       <= 1'b0;
            WA       <= '0;
            WD       <= '0;
            clr_done <= 1'b0;
            cnt      <= '0;
            ptr      <= 1'b1;
        end else begin
            WE       <= 1'b0;
            clr_done <= 1'b0;
            if (state == ST_CLEAR) begin
                WE <= 1'b1;
                WA <= cnt;
                WD <= '0;
                if (cnt == CNT_LAST) begin
                    clr_done <= 1'b1;
                end else begin
                    cnt <= cnt + ADDR'(1);
                end
            end else if (clr) begin
                cnt <= ADDR'(1);
            end else if (grant0) begin
                WE  <= (a0 != '0);
                WA  <= a0;
                WD  <= d0;
                ptr <= 1'b0;
            end else if (grant1) begin
                WE  <= (a1 != '0);
                WA  <= a1;
                WD  <= d1;
                ptr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: scenario tasks push expected writes into a
// scoreboard that is drained against the registered write port every cycle.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, clr = 1'b0;
    logic [4:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        r0, r1, busy, clr_done, WE;
    logic [4:0]  WA;
    logic [31:0] WD;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          at;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;
    exp_t sb[$];

    regfile_wb_arbiter #(.DATA(32), .ADDR(5)) dut (
        .clk(clk), .rst(rst),
        .v0(v0), .a0(a0), .d0(d0), .r0(r0),
        .v1(v1), .a1(a1), .d1(d1), .r1(r1),
        .clr(clr), .busy(busy), .clr_done(clr_done),
        .WE(WE), .WA(WA), .WD(WD)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Expected write visible after the edge following the current negedge
    task automatic push_wr(input int ahead, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.at = cyc + ahead;
        e.we = (a != 5'd0);
        e.wa = a;
        e.wd = d;
        sb.push_back(e);
    endtask

    // Scoreboard drain: compare the write port just after every edge
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            checks++; errors++;
            $display("FAIL missed_write: expected WA=%0d at cycle %0d, now %0d", sb[0].wa, sb[0].at, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].at == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({WE, WA, WD} !== {e.we, e.wa, e.wd}) begin
                errors++;
                $display("FAIL write_port cyc=%0d: got WE=%b WA=%0d WD=%h, need WE=%b WA=%0d WD=%h",
                         cyc, WE, WA, WD, e.we, e.wa, e.wd);
            end
        end else begin
            checks++;
            if (WE !== 1'b0) begin
                errors++;
                $display("FAIL idle_we cyc=%0d: got WE=%b WA=%0d, need WE=0", cyc, WE, WA);
            end
        end
    end

    task automatic test_reset();
        v0 = 1'b1; a0 = 5'd1; d0 = 32'hA0A0_0001;
        v1 = 1'b1; a1 = 5'd2; d1 = 32'hB0B0_0002;
        repeat (2) @(negedge clk);
        checks++;
        if ({WE, WA, WD, busy, clr_done} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got WE=%b WA=%0d WD=%h busy=%b done=%b, need all 0",
                     WE, WA, WD, busy, clr_done);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({r0, r1} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant: got r0=%b r1=%b, need r0=1 r1=0", r0, r1);
        end
        push_wr(1, a0, d0);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        checks++;
        if ({r0, r1} !== 2'b01) begin
            errors++;
            $display("FAIL reset_second_grant: got r0=%b r1=%b, need r0=0 r1=1", r0, r1);
        end
        push_wr(1, a1, d1);
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic test_single_write();
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (r0 !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got r0=%b, need 1", r0);
        end
        push_wr(1, a0, d0);
        @(negedge clk);
        v0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_x0_write();
        v1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (r1 !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got r1=%b, need 1", r1);
        end
        push_wr(1, a1, d1);
        @(negedge clk);
        v1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        logic exp_g;
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h11;
        v1 = 1'b1; a1 = 5'd7; d1 = 32'h22;
        exp_g = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({r0, r1} !== {~exp_g, exp_g}) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got r0=%b r1=%b, need grant %0d", i, r0, r1, exp_g);
            end
            if (exp_g) push_wr(1, a1, d1);
            else       push_wr(1, a0, d0);
            exp_g = ~exp_g;
            @(negedge clk);
        end
        v1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({r0, r1} !== 2'b10) begin
                errors++;
                $display("FAIL solo_grant[%0d]: got r0=%b r1=%b, need r0=1 r1=0", i, r0, r1);
            end
            push_wr(1, a0, d0);
            @(negedge clk);
        end
        v0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clear_sweep();
        int base;
        v0 = 1'b1; a0 = 5'd9; d0 = 32'h5555_AAAA;
        clr = 1'b1;
        base = cyc;
        #1;
        checks++;
        if (r0 !== 1'b0) begin
            errors++;
            $display("FAIL clear_req_ready: got r0=%b, need 0", r0);
        end
        for (int j = 1; j <= 31; j++) push_wr(1 + j, 5'(j), 32'd0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 2) clr = 1'b0;   // clr held into CLEAR must be ignored
            #1;
            checks++;
            if (i < 31) begin
                if ({r0, busy, clr_done} !== 3'b010) begin
                    errors++;
                    $display("FAIL clear_state[%0d]: got r0=%b busy=%b done=%b, need 0/1/0", i, r0, busy, clr_done);
                end
            end else begin
                if ({r0, busy, clr_done} !== 3'b101) begin
                    errors++;
                    $display("FAIL clear_exit: got r0=%b busy=%b done=%b, need 1/0/1", r0, busy, clr_done);
                end
                push_wr(1, a0, d0);
            end
        end
        @(negedge clk);
        v0 = 1'b0;
        #1;
        checks++;
        if ({busy, clr_done} !== 2'b00) begin
            errors++;
            $display("FAIL clear_done_pulse: got busy=%b done=%b, need 0/0", busy, clr_done);
        end
        checks++;
        if (cyc != base + 33) begin
            errors++;
            $display("FAIL clear_timing: sweep took %0d cycles, need 33", cyc - base);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_clear();
        clr = 1'b1;
        for (int j = 1; j <= 10; j++) push_wr(1 + j, 5'(j), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({WE, busy, clr_done} !== 3'b000) begin
            errors++;
            $display("FAIL mid_clear_reset: got WE=%b busy=%b done=%b, need 0/0/0", WE, busy, clr_done);
        end
        @(negedge clk);
        clr = 1'b1;
        for (int j = 1; j <= 31; j++) push_wr(1 + j, 5'(j), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            checks++;
            if (clr_done !== (i == 30)) begin
                errors++;
                $display("FAIL restart_done[%0d]: got done=%b, need %b", i, clr_done, (i == 30));
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_x0_write();
        test_contention();
        test_clear_sweep();
        test_reset_mid_clear();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending writes, need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
